// File: rtl/cache_controller_pkg.sv
// Shared geometry, address field layout and FSM encoding for the cache controller.
package cache_pkg;

   localparam int ADDR_W         = 10;
   localparam int WORD_W         = 32;
   localparam int WORDS_PER_LINE = 4;
   localparam int NUM_LINES      = 4;

   localparam int BYTE_OFF_W  = 2;
   localparam int WORD_SEL_W  = $clog2(WORDS_PER_LINE);
   localparam int INDEX_W     = $clog2(NUM_LINES);
   localparam int LINE_OFF_W  = WORD_SEL_W + BYTE_OFF_W;
   localparam int TAG_W       = ADDR_W - INDEX_W - LINE_OFF_W;
   localparam int LINE_ADDR_W = ADDR_W - LINE_OFF_W;
   localparam int LINE_W      = WORD_W * WORDS_PER_LINE;

   // Bit offsets of each field inside a byte address.
   localparam int BYTE_LSB  = 0;
   localparam int WORD_LSB  = BYTE_OFF_W;
   localparam int INDEX_LSB = LINE_OFF_W;
   localparam int TAG_LSB   = LINE_OFF_W + INDEX_W;

   typedef enum logic [1:0] {
      ST_COMPARE    = 2'd0,
      ST_WRITE_BACK = 2'd1,
      ST_ALLOCATE   = 2'd2
   } cache_state_e;

   // Load-byte result: the selected byte sign-extended to a full word.
   function automatic logic [WORD_W-1:0] sext_byte(input logic [7:0] b);
      return {{(WORD_W-8){b[7]}}, b};
   endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU request bus and block-wide memory bus of the cache controller.
//
// Handshakes: the CPU raises request with stable read_write/if_lb/address/
// write_data and holds them until hit_miss=1 is seen in the same cycle; the
// request completes at that rising edge. On the memory side the controller
// holds mem_req/mem_we/mem_addr/mem_wdata stable for the whole transaction,
// and the memory ends it with a single-cycle mem_ready pulse (carrying
// mem_rdata on a fill).
interface cache_cpu_if;
   import cache_pkg::*;

   logic                request;
   logic                read_write;
   logic                if_lb;
   logic [ADDR_W-1:0]   address;
   logic [WORD_W-1:0]   write_data;
   logic                hit_miss;
   logic [WORD_W-1:0]   read_data;

   modport master (
      output request, read_write, if_lb, address, write_data,
      input  hit_miss, read_data
   );

   modport slave (
      input  request, read_write, if_lb, address, write_data,
      output hit_miss, read_data
   );
endinterface

interface cache_mem_if;
   import cache_pkg::*;

   logic                   mem_req;
   logic                   mem_we;
   logic [LINE_ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0]      mem_wdata;
   logic [LINE_W-1:0]      mem_rdata;
   logic                   mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/cache_controller_line_array.sv
// Tag/valid/dirty state and line storage, asynchronously read at one index.
// Valid/dirty are cleared by reset; tags and data are deliberately not reset.
module cache_line_array
   import cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [INDEX_W-1:0]    index_i,
   output logic                  rd_valid_o,
   output logic                  rd_dirty_o,
   output logic [TAG_W-1:0]      rd_tag_o,
   output logic [LINE_W-1:0]     rd_line_o,
   input  logic                  wr_word_en_i,
   input  logic [WORD_SEL_W-1:0] wr_word_sel_i,
   input  logic [WORD_W-1:0]     wr_word_i,
   input  logic                  fill_en_i,
   input  logic [TAG_W-1:0]      fill_tag_i,
   input  logic [LINE_W-1:0]     fill_line_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   // Valid/dirty bookkeeping: fill makes a line clean, a word write dirties it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_en_i) begin
         valid_q[index_i] <= 1'b1;
         dirty_q[index_i] <= 1'b0;
      end else if (wr_word_en_i) begin
         dirty_q[index_i] <= 1'b1;
      end
   end

   // Tag and data storage; updates are suppressed on a reset edge so an
   // abandoned fill leaves no trace.
   always_ff @(posedge clk) begin
      if (rst_n && fill_en_i) begin
         tag_q[index_i]  <= fill_tag_i;
         data_q[index_i] <= fill_line_i;
      end else if (rst_n && wr_word_en_i) begin
         data_q[index_i][wr_word_sel_i*WORD_W +: WORD_W] <= wr_word_i;
      end
   end

   // Asynchronous read of the addressed entry.
   always_comb begin
      rd_valid_o = valid_q[index_i];
      rd_dirty_o = dirty_q[index_i];
      rd_tag_o   = tag_q[index_i];
      rd_line_o  = data_q[index_i];
   end

endmodule

// File: rtl/cache_controller.sv
// Write-back, write-allocate, direct-mapped cache controller. Hits complete
// combinationally in COMPARE; misses write back a dirty victim, fill the line,
// and return to COMPARE where the held request re-evaluates as a hit.
module cache_controller
   import cache_pkg::*;
(
   input  logic          clock,
   input  logic          reset_n,
   cache_cpu_if.slave    cpu,
   cache_mem_if.master   mem,
   output cache_state_e  dbg_state_o
);

   cache_state_e state_q, state_d;

   logic [TAG_W-1:0]      req_tag;
   logic [INDEX_W-1:0]    req_index;
   logic [WORD_SEL_W-1:0] req_word;
   logic [BYTE_OFF_W-1:0] req_byte;

   logic                  line_valid;
   logic                  line_dirty;
   logic [TAG_W-1:0]      line_tag;
   logic [LINE_W-1:0]     line_data;
   logic [WORD_W-1:0]     sel_word;
   logic [7:0]            sel_byte;
   logic                  hit;

   logic                  wr_word_en;
   logic                  fill_en;

   assign req_tag   = cpu.address[TAG_LSB   +: TAG_W];
   assign req_index = cpu.address[INDEX_LSB +: INDEX_W];
   assign req_word  = cpu.address[WORD_LSB  +: WORD_SEL_W];
   assign req_byte  = cpu.address[BYTE_LSB  +: BYTE_OFF_W];

   assign sel_word = line_data[req_word*WORD_W +: WORD_W];
   assign sel_byte = sel_word[req_byte*8 +: 8];
   assign hit      = cpu.request && line_valid && (line_tag == req_tag);

   assign dbg_state_o = state_q;

   cache_line_array u_lines (
      .clk           (clock),
      .rst_n         (reset_n),
      .index_i       (req_index),
      .rd_valid_o    (line_valid),
      .rd_dirty_o    (line_dirty),
      .rd_tag_o      (line_tag),
      .rd_line_o     (line_data),
      .wr_word_en_i  (wr_word_en),
      .wr_word_sel_i (req_word),
      .wr_word_i     (cpu.write_data),
      .fill_en_i     (fill_en),
      .fill_tag_i    (req_tag),
      .fill_line_i   (mem.mem_rdata)
   );

   // State register; reset abandons any memory transaction.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_COMPARE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: a miss picks write-back only for a valid dirty victim.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_COMPARE: begin
            if (cpu.request && !hit) begin
               state_d = (line_valid && line_dirty) ? ST_WRITE_BACK : ST_ALLOCATE;
            end
         end
         ST_WRITE_BACK: begin
            if (mem.mem_ready) state_d = ST_ALLOCATE;
         end
         ST_ALLOCATE: begin
            if (mem.mem_ready) state_d = ST_COMPARE;
         end
         default: state_d = ST_COMPARE;
      endcase
   end

   // Outputs: hit response and word write in COMPARE, memory bus otherwise.
   always_comb begin
      cpu.hit_miss  = 1'b0;
      cpu.read_data = '0;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      wr_word_en    = 1'b0;
      fill_en       = 1'b0;
      case (state_q)
         ST_COMPARE: begin
            if (hit) begin
               cpu.hit_miss = 1'b1;
               if (cpu.read_write) begin
                  wr_word_en = 1'b1;
               end else begin
                  cpu.read_data = cpu.if_lb ? sext_byte(sel_byte) : sel_word;
               end
            end
         end
         ST_WRITE_BACK: begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = 1'b1;
            mem.mem_addr  = {line_tag, req_index};
            mem.mem_wdata = line_data;
         end
         ST_ALLOCATE: begin
            mem.mem_req  = 1'b1;
            mem.mem_we   = 1'b0;
            mem.mem_addr = {req_tag, req_index};
            fill_en      = mem.mem_ready;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/cache_controller.md
# cache_controller

Write-back, write-allocate, direct-mapped cache controller between the CPU request port and a block-wide main memory. It owns the tag/valid/dirty state and line storage, services hits in the request cycle, and sequences dirty-line write-back and line fill on misses. The CPU holds its request stable until `hit_miss`=1; the controller is the only master on the memory port.

## Interface
- `ADDR_W`, 10: byte address width.
- `WORDS_PER_LINE`, 4: 32-bit words per line (line = 128 bits).
- `NUM_LINES`, 4: cache lines; index width = log2(`NUM_LINES`).
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `request`  in  1  CPU request valid.
- `read_write`  in  1  1 = write word, 0 = read.
- `if_lb`  in  1  on reads, 1 = load byte, sign-extended; ignored on writes.
- `address`  in  `ADDR_W`  byte address: tag[9:6], index[5:4], word[3:2], byte[1:0].
- `write_data`  in  32  store data.
- `hit_miss`  out  1  1 = request completes this cycle.
- `read_data`  out  32  load result; valid when `hit_miss`=1 on a read.
- `mem_req`  out  1  memory transaction active.
- `mem_we`  out  1  1 = line write-back, 0 = line fill.
- `mem_addr`  out  `ADDR_W`-4  line address {tag, index}.
- `mem_wdata`  out  128  victim line.
- `mem_rdata`  in  128  fill data.
- `mem_ready`  in  1  one-cycle pulse; transaction done.

## Operation
- States: COMPARE, WRITE_BACK, ALLOCATE.
- COMPARE, `request`=0: idle, `hit_miss`=0.
- COMPARE, hit (valid && tag match): `hit_miss`=1 combinationally.
  - Read: `read_data` = addressed word, or the byte selected by `address[1:0]` sign-extended to 32 bits when `if_lb`=1.
  - Write: word written at the edge; dirty set. `address[1:0]` ignored.
- COMPARE, miss: `hit_miss`=0. Victim valid && dirty → WRITE_BACK, else → ALLOCATE.
- WRITE_BACK: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index}, `mem_wdata`=victim line.
  - Hold until `mem_ready`, then → ALLOCATE.
- ALLOCATE: `mem_req`=1, `mem_we`=0, `mem_addr`={request tag, index}.
  - On `mem_ready`: line ← `mem_rdata`, tag updated, valid=1, dirty=0, → COMPARE.
  - The request then re-evaluates as a hit, so a write miss merges in COMPARE.
- Memory outputs are stable for the whole transaction. `mem_ready` outside WRITE_BACK/ALLOCATE is ignored.
- Reset (`reset_n`=0 at an edge, any state):
  - All valid and dirty bits cleared; state → COMPARE.
  - An in-flight memory transaction is abandoned; no line update.
  - Data and tag arrays are not reset.

## Timing
- Outputs after reset: `hit_miss`=0, `read_data`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Hit: 0 wait cycles; `hit_miss` in the first COMPARE cycle.
- Clean miss: 1 (COMPARE) + Nfill + 1 (COMPARE hit) cycles, where Nfill = ALLOCATE cycles up to and including `mem_ready`.
- Dirty miss: adds Nwb WRITE_BACK cycles.
- `hit_miss`, `read_data` are combinational from state, arrays and request inputs. Memory outputs are combinational from state and registered arrays; inputs are stable per the CPU contract.
- Back-to-back hits complete one per cycle.

## Structure
- `cache_pkg`: address field widths and offsets, line width, state encoding.
- Sub-module `cache_line_array`:
  - `NUM_LINES` × (valid, dirty, tag, 128-bit line).
  - Asynchronous read; synchronous word write, line fill, and valid/dirty clear.
- FSM, hit logic and byte select live in `cache_controller`.

## Test plan
- Write miss to empty cache: write 0x3AB @ 0b0110101000 → ALLOCATE for line 0b011010, no WRITE_BACK, `hit_miss`=1 after fill. Read same address → 0x000003AB in 0 wait cycles.
- Dirty conflict: after a write of 0x3AC @ 0b0110101000, read 0b0100101000 → WRITE_BACK with `mem_addr`=0b011010 and word 2 = 0x3AC, then ALLOCATE 0b010010. Reread 0b0110101000 → 0x3AC.
- Write miss plus write-back: 0x3AD @ 0b0110101000 dirty, write 0x3AE @ 0b0101101000 → WRITE_BACK then ALLOCATE. Read back 0x3AE, then 0x3AD.
- Load byte: word 0x000003AD cached @ 0b0110101000; lb @ 0b0110101001 → 0x00000003. Word 0x000080FF, lb byte 1 → 0xFFFFFF80.
- Memory latency: `mem_ready` delayed 0, 1 and 5 cycles → outputs held constant, exactly one fill per miss.
- Reset mid-ALLOCATE: drop `reset_n` for one edge → `mem_req`=0 next cycle. The line stays invalid, and the next access to it misses.
